// File: rtl/out_shift_seq.sv
`default_nettype none
// ============================================================================
// Module   : out_shift_seq
// Purpose  : Sequencer for the OutShiftReg datapath (N2 words of N1 bits).
//            A frame is handled in two phases: a word-parallel load of N2
//            words over a valid/ready handshake, then a bit-serial drain of
//            N1 shift cycles that stalls under downstream backpressure.
//            One-cycle FrameDone pulse per completed frame.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clock     in   clock, all state updates on rising edge
//   Reset     in   synchronous active-high reset
//   Start     in   begin a frame (sampled in IDLE only)
//   Abort     in   cancel current frame, return to IDLE
//   InValid   in   upstream word present on OutShiftReg.In
//   InReady   out  controller accepts a word this cycle
//   OutReady  in   downstream can take a serial bit this cycle
//   SelShift  out  OutShiftReg mode select
//   SelKeep   out  OutShiftReg hold select
//   ShiftFire out  OutShiftReg performs a bit shift at this edge
//   FrameDone out  one-cycle pulse, frame fully drained
//   Busy      out  state != IDLE
//   WordCnt   out  words loaded in current frame
//   BitCnt    out  bits shifted in current frame
//
// Datapath select encoding {SelShift,SelKeep}:
//   00 load word, 01 hold, 10 shift bit, 11 never driven.
// ============================================================================
module out_shift_seq #(
    parameter int N1 = 90,
    parameter int N2 = 6
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       Start,
    input  logic                       Abort,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic                       OutReady,
    output logic                       SelShift,
    output logic                       SelKeep,
    output logic                       ShiftFire,
    output logic                       FrameDone,
    output logic                       Busy,
    output logic [$clog2(N2+1)-1:0]    WordCnt,
    output logic [$clog2(N1+1)-1:0]    BitCnt
);

    localparam int WW = $clog2(N2 + 1);
    localparam int BW = $clog2(N1 + 1);

    localparam logic [WW-1:0] WORD_LAST = WW'(N2 - 1);
    localparam logic [WW-1:0] WORD_FULL = WW'(N2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(N1 - 1);
    localparam logic [BW-1:0] BIT_FULL  = BW'(N1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_HOLD  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WW-1:0]   word_cnt_nxt;
    logic [BW-1:0]   bit_cnt_nxt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= S_IDLE;
            WordCnt <= '0;
            BitCnt  <= '0;
        end else begin
            state   <= state_nxt;
            WordCnt <= word_cnt_nxt;
            BitCnt  <= bit_cnt_nxt;
        end
    end

    assign Busy = (state != S_IDLE);

    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = WordCnt;
        bit_cnt_nxt  = BitCnt;
        SelShift     = 1'b0;
        SelKeep      = 1'b1;
        InReady      = 1'b0;
        ShiftFire    = 1'b0;
        FrameDone    = 1'b0;

        // Abort overrides everything outside IDLE; the defaults above
        // already hold the datapath and drop InReady for this cycle.
        if (Abort && (state != S_IDLE)) begin
            state_nxt    = S_IDLE;
            word_cnt_nxt = '0;
            bit_cnt_nxt  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state_nxt    = S_LOAD;
                        word_cnt_nxt = '0;
                        bit_cnt_nxt  = '0;
                    end
                end
                S_LOAD: begin
                    InReady = 1'b1;
                    if (InValid) begin
                        SelKeep = 1'b0;
                        if (WordCnt != WORD_FULL) begin
                            word_cnt_nxt = WordCnt + WW'(1);
                        end
                        if (WordCnt == WORD_LAST) begin
                            state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // The handoff cycle never shifts; OutReady only arms SHIFT.
                    if (OutReady) begin
                        state_nxt = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (OutReady) begin
                        SelShift  = 1'b1;
                        SelKeep   = 1'b0;
                        ShiftFire = 1'b1;
                        if (BitCnt != BIT_FULL) begin
                            bit_cnt_nxt = BitCnt + BW'(1);
                        end
                        if (BitCnt == BIT_LAST) begin
                            state_nxt = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    FrameDone = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
